// File: rtl/id_stage_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_stage_param                                             |
// | Description : RV32I decode stage: regfile with write-back bypass, imm    |
// |               generation, branch/jump resolution, valid/ready + flush.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module id_stage_param #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int PC_W  = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            flush_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    output logic [XLEN-1:0] imm_o,
    output logic [6:0]      opcode_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [XLEN-1:0] link_o,
    output logic            redirect_o,
    output logic [PC_W-1:0] target_o
);

    localparam int         c_IDX_W     = $clog2(NREGS);
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    logic [XLEN-1:0] r_regs [NREGS];

    logic [6:0]      w_opcode;
    logic            w_is_i, w_is_s, w_is_b, w_is_u, w_is_j;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0] w_rdata1, w_rdata2;
    logic            w_br_taken;
    logic            w_take;
    logic [PC_W+1:0] w_jalr_sum;
    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_target;
    logic [XLEN-1:0] w_link;
    logic            w_capture;
    logic            w_wr_en;
    logic            w_unused_ok;

    assign in_ready  = !out_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush_i;
    assign w_wr_en   = wb_we_i && (wb_rd_i != 5'd0) && (int'(wb_rd_i) < NREGS);

    // Out-of-range and x0 indices read zero; a same-cycle write-back wins over the array.
    function automatic logic [XLEN-1:0] f_read(input logic [4:0] idx);
        logic [XLEN-1:0] v;
        v = '0;
        if (idx != 5'd0 && int'(idx) < NREGS) begin
            if (wb_we_i && wb_rd_i == idx) v = wb_data_i;
            else                           v = r_regs[idx[c_IDX_W-1:0]];
        end
        return v;
    endfunction

    assign w_opcode = instr_i[6:0];

    always_comb begin
        w_is_i  = 1'b0;
        w_is_s  = 1'b0;
        w_is_b  = 1'b0;
        w_is_u  = 1'b0;
        w_is_j  = 1'b0;
        w_imm32 = '0;
        case (w_opcode)
            c_OP_LOAD, c_OP_IMM, c_OP_JALR, c_OP_FENCE, c_OP_SYSTEM: begin
                w_is_i  = 1'b1;
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            c_OP_STORE: begin
                w_is_s  = 1'b1;
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            c_OP_BRANCH: begin
                w_is_b  = 1'b1;
                w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_is_u  = 1'b1;
                w_imm32 = {instr_i[31:12], 12'b0};
            end
            c_OP_JAL: begin
                w_is_j  = 1'b1;
                w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    assign w_imm = XLEN'($signed(w_imm32));
    assign w_rs1 = (w_is_u || w_is_j)           ? 5'd0 : instr_i[19:15];
    assign w_rs2 = (w_is_i || w_is_u || w_is_j) ? 5'd0 : instr_i[24:20];
    assign w_rd  = (w_is_s || w_is_b)           ? 5'd0 : instr_i[11:7];

    always_comb begin
        w_rdata1 = f_read(w_rs1);
        w_rdata2 = f_read(w_rs2);
    end

    always_comb begin
        w_br_taken = 1'b0;
        case (instr_i[14:12])
            3'b000:  w_br_taken = (w_rdata1 == w_rdata2);
            3'b001:  w_br_taken = (w_rdata1 != w_rdata2);
            3'b100:  w_br_taken = ($signed(w_rdata1) <  $signed(w_rdata2));
            3'b101:  w_br_taken = ($signed(w_rdata1) >= $signed(w_rdata2));
            3'b110:  w_br_taken = (w_rdata1 <  w_rdata2);
            3'b111:  w_br_taken = (w_rdata1 >= w_rdata2);
            default: w_br_taken = 1'b0;
        endcase
    end

    // imm>>>2 truncated to PC_W is just imm[PC_W+1:2]; the low bits of rs1+imm only depend on low operand bits.
    assign w_br_target = pc_i + w_imm[PC_W+1:2];
    assign w_jalr_sum  = w_rdata1[PC_W+1:0] + w_imm[PC_W+1:0];
    assign w_target    = (w_opcode == c_OP_JALR) ? w_jalr_sum[PC_W+1:2] : w_br_target;
    assign w_take      = w_is_j || (w_opcode == c_OP_JALR) || (w_is_b && w_br_taken);
    assign w_link      = (XLEN'(pc_i) + XLEN'(1)) << 2;
    assign w_unused_ok = &{1'b0, w_jalr_sum[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[wb_rd_i[c_IDX_W-1:0]] <= wb_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            redirect_o <= 1'b0;
            target_o   <= '0;
            rs1_o      <= '0;
            rs2_o      <= '0;
            rd_o       <= '0;
            rdata1_o   <= '0;
            rdata2_o   <= '0;
            imm_o      <= '0;
            opcode_o   <= '0;
            funct3_o   <= '0;
            funct7_o   <= '0;
            link_o     <= '0;
        end else if (flush_i) begin
            out_valid  <= 1'b0;
            redirect_o <= 1'b0;
        end else if (w_capture) begin
            out_valid  <= 1'b1;
            redirect_o <= w_take;
            target_o   <= w_target;
            rs1_o      <= w_rs1;
            rs2_o      <= w_rs2;
            rd_o       <= w_rd;
            rdata1_o   <= w_rdata1;
            rdata2_o   <= w_rdata2;
            imm_o      <= w_imm;
            opcode_o   <= w_opcode;
            funct3_o   <= instr_i[14:12];
            funct7_o   <= instr_i[31:25];
            link_o     <= w_link;
        end else begin
            redirect_o <= 1'b0;
            if (out_ready) out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_stage_param.sv
`default_nettype none
// Scoreboard bench for id_stage_param: default build with random + directed traffic,
// plus a NREGS=16 / XLEN=64 build for width and wrap cases.
module tb_id_stage_param;

    localparam int PC_W = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            in_valid, in_ready, flush_i, wb_we_i, out_valid, out_ready, redirect_o;
    logic [31:0]     instr_i, wb_data_i, rdata1_o, rdata2_o, imm_o, link_o;
    logic [PC_W-1:0] pc_i, target_o;
    logic [4:0]      wb_rd_i, rs1_o, rs2_o, rd_o;
    logic [6:0]      opcode_o, funct7_o;
    logic [2:0]      funct3_o;

    id_stage_param #(.XLEN(32), .NREGS(32), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .wb_we_i(wb_we_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .out_valid(out_valid),
        .out_ready(out_ready), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .rdata1_o(rdata1_o), .rdata2_o(rdata2_o), .imm_o(imm_o), .opcode_o(opcode_o),
        .funct3_o(funct3_o), .funct7_o(funct7_o), .link_o(link_o),
        .redirect_o(redirect_o), .target_o(target_o)
    );

    logic            b_in_valid, b_in_ready, b_flush, b_we, b_out_valid, b_out_ready, b_redirect;
    logic [31:0]     b_instr;
    logic [PC_W-1:0] b_pc, b_target;
    logic [4:0]      b_rd, b_rs1, b_rs2, b_rd_o;
    logic [63:0]     b_wdata, b_rdata1, b_rdata2, b_imm, b_link;
    logic [6:0]      b_op, b_f7;
    logic [2:0]      b_f3;

    id_stage_param #(.XLEN(64), .NREGS(16), .PC_W(PC_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .instr_i(b_instr), .pc_i(b_pc), .flush_i(b_flush), .wb_we_i(b_we),
        .wb_rd_i(b_rd), .wb_data_i(b_wdata), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .rs1_o(b_rs1), .rs2_o(b_rs2), .rd_o(b_rd_o),
        .rdata1_o(b_rdata1), .rdata2_o(b_rdata2), .imm_o(b_imm), .opcode_o(b_op),
        .funct3_o(b_f3), .funct7_o(b_f7), .link_o(b_link),
        .redirect_o(b_redirect), .target_o(b_target)
    );

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm, link;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
    } exp_t;

    exp_t            q[$];
    exp_t            m_e;
    logic [31:0]     m_rf[32];
    bit              exp_ov_now, m_ov_next, exp_redir_now, exp_redir_next;
    logic [PC_W-1:0] exp_tgt_now, exp_tgt_next;
    int              n_tests = 0;
    int              n_fail  = 0;
    bit              prev_stall = 1'b0;
    logic [173:0]    prev_snap, cur_snap;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [4:0] rd, input logic [2:0] f3);
        return {7'b0, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] idx, input bit we,
                                          input logic [4:0] wrd, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (we && wrd == idx) return wd;
        return m_rf[idx];
    endfunction

    // Reference decode from the RV32I format rules, done in wide signed integers.
    function automatic exp_t model(input logic [31:0] ins, input logic [PC_W-1:0] pc,
                                   input bit we, input logic [4:0] wrd, input logic [31:0] wd,
                                   output bit redir, output logic [PC_W-1:0] tgt);
        exp_t        e;
        logic [6:0]  op;
        longint      imm, t;
        bit          fi, fs, fb, fu, fj, taken;
        logic [31:0] a, b;
        op  = ins[6:0];
        fi  = (op == 7'b0010011) || (op == 7'b0000011) || (op == 7'b1100111) ||
              (op == 7'b1110011) || (op == 7'b0001111);
        fs  = (op == 7'b0100011);
        fb  = (op == 7'b1100011);
        fu  = (op == 7'b0110111) || (op == 7'b0010111);
        fj  = (op == 7'b1101111);
        imm = 0;
        if (fi) imm = longint'($signed(ins[31:20]));
        if (fs) imm = longint'($signed({ins[31:25], ins[11:7]}));
        if (fb) imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        if (fu) imm = longint'($signed({ins[31:12], 12'h000}));
        if (fj) imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        e.rs1  = (fu || fj) ? 5'd0 : ins[19:15];
        e.rs2  = (fi || fu || fj) ? 5'd0 : ins[24:20];
        e.rd   = (fs || fb) ? 5'd0 : ins[11:7];
        a      = mread(e.rs1, we, wrd, wd);
        b      = mread(e.rs2, we, wrd, wd);
        e.rd1  = a;
        e.rd2  = b;
        e.imm  = imm[31:0];
        e.op   = op;
        e.f3   = ins[14:12];
        e.f7   = ins[31:25];
        t      = (longint'(pc) + 1) * 4;
        e.link = t[31:0];
        case (ins[14:12])
            3'd0:    taken = (a == b);
            3'd1:    taken = (a != b);
            3'd4:    taken = ($signed(a) <  $signed(b));
            3'd5:    taken = ($signed(a) >= $signed(b));
            3'd6:    taken = (a <  b);
            3'd7:    taken = (a >= b);
            default: taken = 1'b0;
        endcase
        redir = fj || (op == 7'b1100111) || (fb && taken);
        if (op == 7'b1100111) t = (longint'(a) + imm) >>> 2;
        else                  t = longint'(pc) + (imm >>> 2);
        tgt = t[PC_W-1:0];
        return e;
    endfunction

    // One clock of stimulus for the main instance; entered and left at posedge+1.
    task automatic cyc(input bit iv, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                       input bit ordy = 1'b1, input bit fl = 1'b0, input bit we = 1'b0,
                       input logic [4:0] wrd = 5'd0, input logic [31:0] wd = 32'd0);
        bit              cap, r;
        logic [PC_W-1:0] t;
        exp_ov_now    = m_ov_next;
        exp_redir_now = exp_redir_next;
        exp_tgt_now   = exp_tgt_next;
        in_valid  = iv;
        instr_i   = ins;
        pc_i      = pc;
        out_ready = ordy;
        flush_i   = fl;
        wb_we_i   = we;
        wb_rd_i   = wrd;
        wb_data_i = wd;
        cap = iv && !fl && (!exp_ov_now || ordy);
        exp_redir_next = 1'b0;
        if (cap) begin
            q.push_back(model(ins, pc, we, wrd, wd, r, t));
            exp_redir_next = r;
            exp_tgt_next   = t;
        end
        if (we && wrd != 5'd0) m_rf[wrd] = wd;
        m_ov_next = fl ? 1'b0 : cap ? 1'b1 : ordy ? 1'b0 : exp_ov_now;
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        cyc(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b1, rd, d);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush_i  = 1'b0;
        wb_we_i  = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_redirect", redirect_o, 0);
        chk("rst_target", target_o, 0);
        q.delete();
        foreach (m_rf[i]) m_rf[i] = 32'd0;
        exp_ov_now = 0; m_ov_next = 0; exp_redir_now = 0; exp_redir_next = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            chk("out_valid", out_valid, exp_ov_now);
            chk("redirect", redirect_o, exp_redir_now);
            if (exp_redir_now) chk("target", target_o, exp_tgt_now);
            cur_snap = {rs1_o, rs2_o, rd_o, rdata1_o, rdata2_o, imm_o, opcode_o,
                        funct3_o, funct7_o, link_o, target_o};
            if (prev_stall) begin
                n_tests++;
                if (cur_snap !== prev_snap) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h expected %h", cur_snap, prev_snap);
                end
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got bundle op=%h expected none", opcode_o);
                end else begin
                    m_e = q.pop_front();
                    chk("rs1", rs1_o, m_e.rs1);
                    chk("rs2", rs2_o, m_e.rs2);
                    chk("rd", rd_o, m_e.rd);
                    chk("rdata1", rdata1_o, m_e.rd1);
                    chk("rdata2", rdata2_o, m_e.rd2);
                    chk("imm", imm_o, m_e.imm);
                    chk("opcode", opcode_o, m_e.op);
                    chk("funct3", funct3_o, m_e.f3);
                    chk("funct7", funct7_o, m_e.f7);
                    chk("link", link_o, m_e.link);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_snap  = cur_snap;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  ops[12];
        logic [31:0] ins, wd;
        logic [6:0]  op;
        bit          ordy;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
                7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011, 7'b0001111, 7'b0000000};
        foreach (m_rf[i]) m_rf[i] = 32'd0;
        exp_ov_now = 0; m_ov_next = 0; exp_redir_now = 0; exp_redir_next = 0;
        exp_tgt_now = '0; exp_tgt_next = '0;
        in_valid = 0; instr_i = 0; pc_i = 0; flush_i = 0; out_ready = 1;
        wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0;
        b_in_valid = 0; b_instr = 0; b_pc = 0; b_flush = 0; b_we = 0; b_rd = 0;
        b_wdata = 0; b_out_ready = 1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_redirect", redirect_o, 0);
        chk("reset_target", target_o, 0);
        chk("reset_rdata1", rdata1_o, 0);
        chk("reset_imm", imm_o, 0);
        chk("reset_rd", rd_o, 0);
        chk("reset_link", link_o, 0);
        chk("reset_b_out_valid", b_out_valid, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Same-cycle write-back is bypassed into the captured operands.
        cyc(1, enc_r(5'd3, 5'd3, 5'd4, 3'd0), 14'h5, 1, 0, 1, 5'd3, 32'hDEADBEEF);
        chk("bypass_rdata1", rdata1_o, 32'hDEADBEEF);
        chk("bypass_rdata2", rdata2_o, 32'hDEADBEEF);

        wb(5'd1, 32'd5);
        wb(5'd2, 32'hFFFF_FFFF);
        wb(5'd7, 32'h103);
        cyc(1, enc_b(13'd16, 5'd2, 5'd1, 3'b100), 14'h10);
        chk("blt_not_taken", redirect_o, 0);
        cyc(1, enc_b(13'd16, 5'd2, 5'd1, 3'b110), 14'h10);
        chk("bltu_redirect", redirect_o, 1);
        chk("bltu_target", target_o, 14'h14);
        cyc(0, 32'd0, '0);
        chk("bltu_pulse_end", redirect_o, 0);
        cyc(1, enc_b(13'h1FF8, 5'd2, 5'd1, 3'b101), 14'h10);
        chk("bge_redirect", redirect_o, 1);
        chk("bge_target", target_o, 14'h0E);
        cyc(1, enc_i(12'd5, 5'd7, 3'd0, 5'd1, 7'b1100111), 14'h20);
        chk("jalr_redirect", redirect_o, 1);
        chk("jalr_target", target_o, 14'h42);
        chk("jalr_link", link_o, 32'h84);
        cyc(0, 32'd0, '0);
        chk("jalr_pulse_end", redirect_o, 0);

        // Back-pressure: three stalled cycles with a new instruction waiting.
        cyc(1, enc_i(12'h123, 5'd1, 3'd0, 5'd9, 7'b0010011), 14'h30);
        for (int k = 0; k < 3; k++) begin
            cyc(1, enc_j(21'd8, 5'd1), 14'h31, 0);
            chk("stall_in_ready", in_ready, 0);
        end
        cyc(0, 32'd0, '0);

        // Reset while a bundle is stalled drops it and clears the register file.
        wb(5'd5, 32'h55);
        cyc(1, enc_i(12'd1, 5'd0, 3'd0, 5'd9, 7'b0010011), 14'h40);
        cyc(0, 32'd0, '0, 0);
        chk("stall_valid_before_reset", out_valid, 1);
        do_reset();
        cyc(1, enc_r(5'd0, 5'd5, 5'd6, 3'd0), 14'h1);
        chk("x5_after_reset", rdata1_o, 0);

        // Flush with a valid jump presented: nothing captured, no redirect.
        cyc(1, enc_j(21'd8, 5'd1), 14'h0, 1, 1);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_redirect", redirect_o, 0);

        // NREGS=16, XLEN=64 build.
        b_we = 1; b_rd = 5'd20; b_wdata = 64'h1234;
        cyc(0, 32'd0, '0);
        b_we = 0; b_in_valid = 1; b_instr = enc_r(5'd0, 5'd20, 5'd1, 3'd0); b_pc = '0;
        cyc(0, 32'd0, '0);
        b_in_valid = 0;
        chk("b_valid", b_out_valid, 1);
        chk("b_x20_reads_zero", b_rdata1, 0);
        b_we = 1; b_rd = 5'd5; b_wdata = 64'hCAFE_0000_1234_5678;
        cyc(0, 32'd0, '0);
        b_we = 0; b_in_valid = 1; b_instr = enc_r(5'd5, 5'd5, 5'd1, 3'd0);
        cyc(0, 32'd0, '0);
        b_in_valid = 0;
        chk("b_x5_64bit", b_rdata1, 64'hCAFE_0000_1234_5678);
        b_in_valid = 1; b_instr = enc_j(21'h1FFFFC, 5'd1); b_pc = '0;
        cyc(0, 32'd0, '0);
        b_in_valid = 0;
        chk("b_jal_wrap_target", b_target, 14'h3FFF);
        chk("b_jal_redirect", b_redirect, 1);
        chk("b_jal_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("b_jal_link", b_link, 64'd4);

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            ins = $urandom();
            op  = ops[$urandom_range(0, 11)];
            if (op == 7'b0000000) op = 7'($urandom());
            ins[6:0] = op;
            if ($urandom_range(0, 1) == 1) begin
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
            end
            case ($urandom_range(0, 4))
                0:       wd = 32'd0;
                1:       wd = 32'd1;
                2:       wd = 32'hFFFF_FFFF;
                3:       wd = 32'h8000_0000;
                default: wd = $urandom();
            endcase
            ordy = ($urandom_range(0, 3) != 0);
            cyc($urandom_range(0, 3) != 0, ins, 14'($urandom_range(0, 16383)), ordy,
                ordy && ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 31)), wd);
        end
        for (int k = 0; k < 3; k++) cyc(0, 32'd0, '0);
        chk("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_stage_param.md
# id_stage_param

Parametrised RV32I instruction-decode stage: register file, immediate generation, and branch/jump resolution, with a valid/ready handshake on both sides and flush support. It sits between the fetch stage (word-addressed PC) and the execute stage. It extends the single-cycle decoder with:
- configurable data width and register count,
- pipeline back-pressure and flush,
- write-back bypass,
- a registered redirect output to fetch.

## Interface
Parameters:
- XLEN, 32, data/register width (≥32)
- NREGS, 32, architectural register count (16 or 32); indices ≥ NREGS read 0, writes ignored
- PC_W, 14, width of word-addressed PC

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts instruction this cycle
- instr_i  in  32  instruction word
- pc_i  in  PC_W  word address of instr_i
- flush_i  in  1  discard output register contents and suppress capture
- wb_we_i  in  1  write-back enable
- wb_rd_i  in  5  write-back destination
- wb_data_i  in  XLEN  write-back data
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes bundle
- rs1_o, rs2_o, rd_o  out  5  register indices
- rdata1_o, rdata2_o  out  XLEN  operand values
- imm_o  out  XLEN  sign-extended immediate
- opcode_o  out  7  instr[6:0]; funct3_o out 3; funct7_o out 7
- link_o  out  XLEN  return address for JAL/JALR, byte address ((pc_i+1)<<2), zero-extended
- redirect_o  out  1  one-cycle pulse: fetch must jump
- target_o  out  PC_W  redirect word address

## Operation
- Handshake: in_ready = !out_valid | out_ready. Capture occurs when in_valid & in_ready & !flush_i.
- On capture, the output register loads all decoded fields and sets out_valid=1. Otherwise, if out_ready, out_valid clears.
- flush_i has priority: next cycle out_valid=0 and redirect_o=0; no capture that cycle.
- Register file: NREGS×XLEN. Write on rising edge when wb_we_i & wb_rd_i≠0 & wb_rd_i<NREGS. x0 always reads 0.
- Bypass: when a read index equals wb_rd_i with wb_we_i=1 and index≠0 in the capture cycle, the operand takes wb_data_i.
- Field extraction: rs1/rs2/rd are taken from fixed positions for every format. Unused fields are forced to 0:
  - I, U, J: rs2=0
  - U, J: rs1=0
  - S, B: rd=0
- Immediates (I, S, B, U, J) follow RV32I encoding, sign-extended to XLEN. R-type and unknown opcodes give imm=0.
- Branch compare (opcode 1100011) uses bypassed operands:
  - BEQ, BNE: equality
  - BLT, BGE: signed compare
  - BLTU, BGEU: unsigned compare
  - funct3 010/011 are never taken.
- Targets, all truncated to PC_W (wrap-around modulo 2^PC_W):
  - Branch and JAL: pc_i + (imm >>> 2), arithmetic shift.
  - JALR: ((rs1 + imm) & ~1) >> 2.
- redirect_o=1 for one cycle with the captured instruction when the branch is taken, or for JAL/JALR. It is cleared the next cycle regardless of out_ready.
- JAL/JALR keep their rd; execute writes link_o.

## Timing
- Latency is 1 cycle from capture to out_valid/redirect_o.
- Stall: if out_valid & !out_ready, all outputs hold and in_ready=0. redirect_o does not re-pulse during the stall.
- Reset (asynchronous, active-low):
  - out_valid=0, redirect_o=0, target_o=0
  - all data and index outputs =0
  - all registers =0
- Reset during a stall drops the bundle. Reset release takes effect on the next rising edge.
- Write-back and decode in the same cycle: bypass guarantees the new value is captured.
- Write-back to a register while a stalled bundle holds an old operand: the held operand is not updated (execute forwarding owns that case).

## Test plan
- Reset mid-stall: hold out_ready=0 with a valid bundle, pulse rst_n low → out_valid=0 immediately; x5 reads 0 afterwards.
- Bypass: wb x3=0xDEAD_BEEF in the same cycle that `add x4,x3,x3` is captured → rdata1_o=rdata2_o=0xDEADBEEF one cycle later.
- Branches: x1=5, x2=-1, pc=0x10, offset +16:
  - BLT → not taken.
  - BLTU → redirect_o pulse, target_o=0x14.
  - BGE with offset -8 → target_o=0x0E.
- JALR: x7=0x103, imm=+5, pc=0x20 → target_o=0x42, link_o=0x84, redirect_o pulses once.
- Back-pressure and flush:
  - out_ready=0 for 3 cycles → outputs stable, in_ready=0.
  - flush_i asserted with in_valid=1 → next cycle out_valid=0, no redirect.
- Width and wrap: NREGS=16, XLEN=64 build; write x20 → ignored, reads 0. JAL offset -4 at pc=0 → target_o=0x3FFF for PC_W=14.
